// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the multi-cycle processor control unit:
// opcode values, step encoding and ALU operation codes.
package proc_ctrl_pkg;

  localparam int OP_MV   = 0;
  localparam int OP_MVI  = 1;
  localparam int OP_ADD  = 2;
  localparam int OP_SUB  = 3;
  localparam int OP_AND  = 4;
  localparam int OP_MVNZ = 5;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  // Register index width; a single-register file still needs a 1-bit field.
  function automatic int reg_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/proc_reg_decoder.sv
// Binary register index to one-hot enable; indices beyond the register
// file decode to all-zero.
module proc_reg_decoder
  import proc_ctrl_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = reg_aw(NREG)
) (
  input  logic [AW-1:0]   idx,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = en && (idx == AW'(i));
    end
  end

endmodule

// File: rtl/proc_ctrl_unit.sv
// Multi-cycle processor controller: fetches an instruction in T0 and
// sequences T1..T3, driving register enables, bus selects and ALU controls.
module proc_ctrl_unit
  import proc_ctrl_pkg::*;
#(
  parameter int DATA_W = 9,
  parameter int OPC_W  = 3,
  parameter int NREG   = 8
) (
  input  logic              clock,
  input  logic              aReset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              g_zero,
  output logic              IRin,
  output logic [NREG-1:0]   Rin,
  output logic [NREG-1:0]   Rout,
  output logic              DINout,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic [1:0]        alu_op,
  output logic              Done,
  output logic              err
);

  localparam int REG_AW = reg_aw(NREG);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   ir;
  logic [OPC_W-1:0]    opc;
  logic [REG_AW-1:0]   x_idx, y_idx, rout_idx;
  logic                rin_en, rout_en;
  logic                is_mv, is_mvi, is_mvnz, is_alu, is_illegal;
  logic [1:0]          alu_sel;
  logic                ir_unused;

  assign opc   = ir[DATA_W-1 -: OPC_W];
  assign x_idx = ir[DATA_W-1-OPC_W -: REG_AW];
  assign y_idx = ir[DATA_W-1-OPC_W-REG_AW -: REG_AW];
  // Trailing IR bits below the Y field carry no control meaning.
  assign ir_unused = ^ir;

  always_comb begin
    is_mv      = 1'b0;
    is_mvi     = 1'b0;
    is_mvnz    = 1'b0;
    is_alu     = 1'b0;
    is_illegal = 1'b0;
    alu_sel    = ALU_ADD;
    case (opc)
      OPC_W'(OP_MV):   is_mv   = 1'b1;
      OPC_W'(OP_MVI):  is_mvi  = 1'b1;
      OPC_W'(OP_MVNZ): is_mvnz = 1'b1;
      OPC_W'(OP_ADD):  is_alu  = 1'b1;
      OPC_W'(OP_SUB):  begin is_alu = 1'b1; alu_sel = ALU_SUB; end
      OPC_W'(OP_AND):  begin is_alu = 1'b1; alu_sel = ALU_AND; end
      default:         is_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge aReset) begin
    if (aReset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && Run) ir <= DataIn;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      T0: if (Run) state_nxt = T1;
      T1: state_nxt = is_alu ? T2 : T0;
      T2: state_nxt = T3;
      T3: state_nxt = T0;
      default: state_nxt = T0;
    endcase
  end

  // Outputs are forced low for the whole time reset is held, including IRin.
  always_comb begin
    IRin     = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = y_idx;
    DINout   = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    alu_op   = ALU_ADD;
    Done     = 1'b0;
    err      = 1'b0;
    if (!aReset) begin
      case (state)
        T0: IRin = Run;
        T1: begin
          if (is_mv) begin
            rout_en = 1'b1;
            rin_en  = 1'b1;
            Done    = 1'b1;
          end else if (is_mvi) begin
            DINout = 1'b1;
            rin_en = 1'b1;
            Done   = 1'b1;
          end else if (is_mvnz) begin
            rout_en = !g_zero;
            rin_en  = !g_zero;
            Done    = 1'b1;
          end else if (is_alu) begin
            rout_en  = 1'b1;
            rout_idx = x_idx;
            Ain      = 1'b1;
          end else if (is_illegal) begin
            err  = 1'b1;
            Done = 1'b1;
          end
        end
        T2: begin
          rout_en = 1'b1;
          Gin     = 1'b1;
          alu_op  = alu_sel;
        end
        T3: begin
          Gout   = 1'b1;
          rin_en = 1'b1;
          Done   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  proc_reg_decoder #(.NREG(NREG), .AW(REG_AW)) u_rin_dec (
    .idx    (x_idx),
    .en     (rin_en),
    .onehot (Rin)
  );

  proc_reg_decoder #(.NREG(NREG), .AW(REG_AW)) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

  a_one_rin : assert property (@(posedge clock) disable iff (aReset) $onehot0(Rin));
  a_one_bus : assert property (@(posedge clock) disable iff (aReset)
                               $onehot0({Rout, DINout, Gout}));

endmodule

// File: tb/tb_proc_ctrl_unit.sv
// Scoreboard bench for proc_ctrl_unit: default 9-bit instance plus a
// 16-bit / 16-register instance.
module tb_proc_ctrl_unit;

  typedef struct {
    string       nm;
    logic [41:0] v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aReset;
  logic        run_n, gz_n, run_w, gz_w;
  logic [8:0]  din_n;
  logic [15:0] din_w;

  logic        irin_n, dinout_n, ain_n, gin_n, gout_n, done_n, err_n;
  logic [7:0]  rin_n, rout_n;
  logic [1:0]  alu_n;
  logic        irin_w, dinout_w, ain_w, gin_w, gout_w, done_w, err_w;
  logic [15:0] rin_w, rout_w;
  logic [1:0]  alu_w;

  int checks = 0;
  int errors = 0;
  exp_t qn[$];
  exp_t qw[$];

  proc_ctrl_unit dut_n (
    .clock(clk), .aReset(aReset), .Run(run_n), .DataIn(din_n), .g_zero(gz_n),
    .IRin(irin_n), .Rin(rin_n), .Rout(rout_n), .DINout(dinout_n), .Ain(ain_n),
    .Gin(gin_n), .Gout(gout_n), .alu_op(alu_n), .Done(done_n), .err(err_n)
  );

  proc_ctrl_unit #(.DATA_W(16), .OPC_W(4), .NREG(16)) dut_w (
    .clock(clk), .aReset(aReset), .Run(run_w), .DataIn(din_w), .g_zero(gz_w),
    .IRin(irin_w), .Rin(rin_w), .Rout(rout_w), .DINout(dinout_w), .Ain(ain_w),
    .Gin(gin_w), .Gout(gout_w), .alu_op(alu_w), .Done(done_w), .err(err_w)
  );

  // Packed layout: irin, rin[15:0], rout[15:0], dinout, ain, gin, gout, alu[1:0], done, err
  function automatic exp_t mk(input string nm, input logic irin, input logic [15:0] rin,
                              input logic [15:0] rout, input logic dinout, input logic ain,
                              input logic gin, input logic gout, input logic [1:0] alu,
                              input logic done, input logic err);
    exp_t e;
    e.nm = nm;
    e.v  = {irin, rin, rout, dinout, ain, gin, gout, alu, done, err};
    return e;
  endfunction

  task automatic step_n(input logic run, input logic [8:0] din, input logic gz, input exp_t e);
    @(posedge clk); #1;
    run_n = run; din_n = din; gz_n = gz;
    qn.push_back(e);
  endtask

  task automatic step_w(input logic run, input logic [15:0] din, input logic gz, input exp_t e);
    @(posedge clk); #1;
    run_w = run; din_w = din; gz_w = gz;
    qw.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [41:0] a;
    if (qn.size() > 0) begin
      e = qn.pop_front();
      a = {irin_n, 8'h00, rin_n, 8'h00, rout_n, dinout_n, ain_n, gin_n, gout_n, alu_n, done_n, err_n};
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, a, e.v);
      end
    end
    if (qw.size() > 0) begin
      e = qw.pop_front();
      a = {irin_w, rin_w, rout_w, dinout_w, ain_w, gin_w, gout_w, alu_w, done_w, err_w};
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, a, e.v);
      end
    end
  end

  localparam logic [15:0] Z = 16'h0000;

  initial begin
    aReset = 1'b1;
    run_n = 1'b0; din_n = '0; gz_n = 1'b0;
    run_w = 1'b0; din_w = '0; gz_w = 1'b0;

    // Reset held: Run high must not raise IRin
    step_n(1'b1, 9'h000, 1'b0, mk("rst_hold", 0, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    @(posedge clk); #1 aReset = 1'b0; run_n = 1'b0;
    step_n(1'b0, 9'h000, 1'b0, mk("idle_t0", 0, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));

    // mvi R2
    step_n(1'b1, 9'h050, 1'b0, mk("mvi_t0", 1, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("mvi_t1", 0, 16'h0004, Z, 1, 0, 0, 0, 2'b00, 1, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("mvi_back", 0, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));

    // add R1,R2 with Run held high through T1..T3 (ignored)
    step_n(1'b1, 9'h08A, 1'b0, mk("add_t0", 1, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_n(1'b1, 9'h050, 1'b0, mk("add_t1", 0, Z, 16'h0002, 0, 1, 0, 0, 2'b00, 0, 0));
    step_n(1'b1, 9'h050, 1'b0, mk("add_t2", 0, Z, 16'h0004, 0, 0, 1, 0, 2'b00, 0, 0));
    step_n(1'b1, 9'h050, 1'b0, mk("add_t3", 0, 16'h0002, Z, 0, 0, 0, 1, 2'b00, 1, 0));

    // mvnz R3,R4 back-to-back, g_zero=0 then g_zero=1
    step_n(1'b1, 9'h15C, 1'b0, mk("mvnz_t0", 1, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("mvnz_nz", 0, 16'h0008, 16'h0010, 0, 0, 0, 0, 2'b00, 1, 0));
    step_n(1'b1, 9'h15C, 1'b1, mk("mvnz_t0b", 1, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b1, mk("mvnz_z", 0, Z, Z, 0, 0, 0, 0, 2'b00, 1, 0));

    // and R0,R7
    step_n(1'b1, 9'h107, 1'b0, mk("and_t0", 1, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("and_t1", 0, Z, 16'h0001, 0, 1, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("and_t2", 0, Z, 16'h0080, 0, 0, 1, 0, 2'b10, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("and_t3", 0, 16'h0001, Z, 0, 0, 0, 1, 2'b00, 1, 0));

    // Illegal opcode 7
    step_n(1'b1, 9'h1C0, 1'b0, mk("ill_t0", 1, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("ill_t1", 0, Z, Z, 0, 0, 0, 0, 2'b00, 1, 1));
    step_n(1'b0, 9'h000, 1'b0, mk("ill_idle1", 0, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("ill_idle2", 0, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));

    // mv R5,R6 (opc 0): 000 101 110
    step_n(1'b1, 9'h02E, 1'b0, mk("mv_t0", 1, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("mv_t1", 0, 16'h0020, 16'h0040, 0, 0, 0, 0, 2'b00, 1, 0));

    // Reset mid-T2 of add R1,R2
    step_n(1'b1, 9'h08A, 1'b0, mk("rst_add_t0", 1, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("rst_add_t1", 0, Z, 16'h0002, 0, 1, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("rst_add_t2", 0, Z, 16'h0004, 0, 0, 1, 0, 2'b00, 0, 0));
    @(negedge clk); #1 aReset = 1'b1;
    step_n(1'b1, 9'h050, 1'b0, mk("rst_mid", 0, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    @(posedge clk); #1 aReset = 1'b0; run_n = 1'b0;
    step_n(1'b0, 9'h000, 1'b0, mk("rst_after1", 0, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_n(1'b0, 9'h000, 1'b0, mk("rst_after2", 0, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));

    // Wide instance: sub R15,R0 = 0011 1111 0000 0000
    step_w(1'b1, 16'h3F00, 1'b0, mk("w_sub_t0", 1, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_w(1'b0, 16'h0000, 1'b0, mk("w_sub_t1", 0, Z, 16'h8000, 0, 1, 0, 0, 2'b00, 0, 0));
    step_w(1'b0, 16'h0000, 1'b0, mk("w_sub_t2", 0, Z, 16'h0001, 0, 0, 1, 0, 2'b01, 0, 0));
    step_w(1'b0, 16'h0000, 1'b0, mk("w_sub_t3", 0, 16'h8000, Z, 0, 0, 0, 1, 2'b00, 1, 0));
    // Opcode 6 is illegal in the wide encoding as well
    step_w(1'b1, 16'h6000, 1'b0, mk("w_ill_t0", 1, Z, Z, 0, 0, 0, 0, 2'b00, 0, 0));
    step_w(1'b0, 16'h0000, 1'b0, mk("w_ill_t1", 0, Z, Z, 0, 0, 0, 0, 2'b00, 1, 1));

    @(negedge clk); #1;
    if (qn.size() != 0 || qw.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", qn.size(), qw.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
